// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampled UART receiver that writes completed words into the rx fifo.
// Frame: start bit, DATA_WIDTH data bits (LSB first), optional even-parity bit, stop bit.
// Optional feature: define UART_RX_PARITY_EN to add the PARITY state and the o_parity_err output.
`timescale 1ns/1ps

module uart_rx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_rx,
  input  logic                  i_full,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_write,
  output logic                  o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                  o_parity_err,
`endif
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    armed_q, armed_d;
  logic                    rx_meta_q, rx_sync_q;
  logic [1:0]              sync_vld_q;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    write_q, write_d;
  logic                    ferr_q, ferr_d;
  logic                    ovr_q, ovr_d;
  logic                    ovr_set;
  logic                    par_ok;
  logic                    rx_s;
`ifdef UART_RX_PARITY_EN
  logic                    par_bad_q, par_bad_d;
  logic                    perr_q, perr_d;
`endif

  assign rx_s = rx_sync_q;

  // Two-flop synchroniser on the serial line, preset to idle-high. sync_vld_q
  // marks when rx_sync_q holds a real line sample rather than the preset, so a
  // line held low across reset can never arm the receiver.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      sync_vld_q <= '0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_sync_q  <= rx_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // Frame state, counters, shift register and registered fifo-side outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      write_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      write_q   <= write_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state decode; everything except the output pulses advances only on i_tick.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    armed_d = armed_q;
    data_d  = data_q;
    write_d = 1'b0;
    ferr_d  = 1'b0;
    ovr_set = 1'b0;
    par_ok  = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
    par_ok    = ~par_bad_q;
`endif
    if (i_tick) begin
      if (rx_s && sync_vld_q[1]) begin
        armed_d = 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (armed_q && !rx_s) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == MID_TICK) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
            if (bit_q == LAST_BIT) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_q == LAST_TICK) begin
            tick_d    = '0;
            par_bad_d = ^{shift_q, rx_s};
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            state_d = S_IDLE;
            if (rx_s) begin
              if (par_ok) begin
                data_d = shift_q;
                if (i_full) begin
                  ovr_set = 1'b1;
                end else begin
                  write_d = 1'b1;
                end
              end
            end else begin
              ferr_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_d = par_bad_q;
`endif
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      endcase
    end
    // A new overrun outranks a coincident clear.
    ovr_d = (i_clr_err ? 1'b0 : ovr_q) | ovr_set;
  end

  assign o_data      = data_q;
  assign o_write     = write_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: frame-level expectation queue plus per-cycle compare.
// Honours UART_RX_PARITY_EN when defined.
`timescale 1ns/1ps

module tb_uart_rx_framer;

  localparam int DW = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = DW + 1;
`else
  localparam int NBITS = DW;
`endif

  logic          clk = 1'b0;
  logic          rst, tick, rx, full, clr;
  logic [DW-1:0] o_data;
  logic          o_write, o_frame_err, o_overrun, o_busy;
`ifdef UART_RX_PARITY_EN
  logic          o_parity_err;
`endif

  uart_rx_framer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_tick      (tick),
    .i_rx        (rx),
    .i_full      (full),
    .i_clr_err   (clr),
    .o_data      (o_data),
    .o_write     (o_write),
    .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic [DW-1:0] d;
    bit          stop;
    bit          par;
  } ev_t;
  ev_t evq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle index at which a frame whose start bit is first driven at the next
  // posedge shows its completion: 2 sync stages, half a bit to mid-start, then
  // one full bit period per remaining bit up to and including the stop bit.
  function automatic int completion_cycle();
    return cyc + 1 + 2 + OS / 2 + (NBITS + 1) * OS;
  endfunction

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit stop, input bit par);
    ev_t ev;
    ev.cyc  = completion_cycle();
    ev.d    = d;
    ev.stop = stop;
    ev.par  = par;
    evq.push_back(ev);
    hold(1'b0, OS);
    for (int i = 0; i < DW; i++) hold(d[i], OS);
`ifdef UART_RX_PARITY_EN
    hold(par, OS);
`endif
    hold(stop, OS);
  endtask

  task automatic send_ok(input logic [DW-1:0] d);
    send_frame(d, 1'b1, ^d);
  endtask

  // Per-cycle compare against the frame-level model.
  initial begin : compare
    ev_t           ev;
    logic [DW-1:0] m_data;
    bit            m_ovr, ew, ef, ep, pbad;
    m_data = '0;
    m_ovr  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ew = 1'b0;
      ef = 1'b0;
      ep = 1'b0;
      if (rst) begin
        evq.delete();
        m_data = '0;
        m_ovr  = 1'b0;
      end else begin
        if (clr) m_ovr = 1'b0;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          ev = evq.pop_front();
`ifdef UART_RX_PARITY_EN
          pbad = ((^ev.d) ^ ev.par) != 1'b0;
`else
          pbad = 1'b0;
`endif
          ep = pbad;
          if (!ev.stop) begin
            ef = 1'b1;
          end else if (!pbad) begin
            m_data = ev.d;
            if (full) m_ovr = 1'b1;
            else      ew    = 1'b1;
          end
        end
      end
      chk("write", o_write, ew);
      chk("frame_err", o_frame_err, ef);
      chk("data", o_data, m_data);
      chk("overrun", o_overrun, m_ovr);
`ifdef UART_RX_PARITY_EN
      chk("parity_err", o_parity_err, ep);
`else
      chk("no_parity_pulse", ep, 1'b0);
`endif
    end
  end

  initial begin : stimulus
    int e;
    rst  = 1'b1;
    tick = 1'b1;
    rx   = 1'b1;
    full = 1'b0;
    clr  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_data", o_data, 8'h00);
    chk("reset_write", o_write, 1'b0);
    chk("reset_overrun", o_overrun, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    hold(1'b1, 2 * OS);

    // Plain word, exact completion timing.
    e = completion_cycle();
    fork
      send_ok(8'hA5);
      begin
        repeat (40) @(negedge clk);
        chk("a5_busy_mid", o_busy, 1'b1);
        wait_cyc(e - 1);
        chk("a5_write_before", o_write, 1'b0);
        @(negedge clk);
        chk("a5_write_at", o_write, 1'b1);
        chk("a5_data_at", o_data, 8'hA5);
        @(negedge clk);
        chk("a5_write_after", o_write, 1'b0);
      end
    join
    hold(1'b1, OS);
    chk("a5_busy_after", o_busy, 1'b0);

    // Start-bit glitch: aborted at mid-bit check.
    hold(1'b0, 4);
    hold(1'b1, 6);
    chk("glitch_busy_during", o_busy, 1'b1);
    hold(1'b1, 2 * OS);
    chk("glitch_busy_after", o_busy, 1'b0);
    chk("glitch_data", o_data, 8'hA5);

    // Framing error.
    e = completion_cycle();
    fork
      send_frame(8'h3C, 1'b0, ^8'h3C);
      begin
        wait_cyc(e);
        chk("fe_pulse", o_frame_err, 1'b1);
        chk("fe_no_write", o_write, 1'b0);
      end
    join
    hold(1'b1, 2 * OS);
    chk("fe_data_kept", o_data, 8'hA5);
    chk("fe_busy_after", o_busy, 1'b0);

    // Back-to-back frames with no idle gap.
    send_ok(8'h12);
    send_ok(8'h34);
    hold(1'b1, 2 * OS);
    chk("b2b_data", o_data, 8'h34);

    // Overrun, sticky until cleared.
    full = 1'b1;
    send_ok(8'h55);
    hold(1'b1, OS);
    full = 1'b0;
    chk("ovr_set", o_overrun, 1'b1);
    chk("ovr_data", o_data, 8'h55);
    hold(1'b1, 10);
    chk("ovr_sticky", o_overrun, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_cleared", o_overrun, 1'b0);

    // Overrun coinciding with a clear: set wins.
    full = 1'b1;
    e = completion_cycle();
    fork
      send_ok(8'h66);
      begin
        wait_cyc(e - 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
    join
    hold(1'b1, OS);
    full = 1'b0;
    chk("ovr_set_wins", o_overrun, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_cleared2", o_overrun, 1'b0);

    // Reset part way through a frame with the line held low afterwards.
    hold(1'b0, 4 * OS);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 20);
    chk("rst_busy_low_line", o_busy, 1'b0);
    chk("rst_data", o_data, 8'h00);
    hold(1'b0, 20);
    hold(1'b1, 2 * OS);
    send_ok(8'h81);
    hold(1'b1, 2 * OS);
    chk("rst_then_81", o_data, 8'h81);

    // No ticks: a low line must not advance the receiver.
    tick = 1'b0;
    hold(1'b0, 20);
    chk("notick_busy", o_busy, 1'b0);
    hold(1'b1, 4);
    tick = 1'b1;
    hold(1'b1, 2 * OS);
    chk("notick_busy_after", o_busy, 1'b0);
    send_ok(8'h5A);
    hold(1'b1, OS);
    chk("notick_then_5a", o_data, 8'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, OS);
    chk("par_good_data", o_data, 8'h07);
    e = completion_cycle();
    fork
      send_frame(8'hF0, 1'b1, 1'b1);
      begin
        wait_cyc(e);
        chk("par_bad_pulse", o_parity_err, 1'b1);
        chk("par_bad_no_write", o_write, 1'b0);
      end
    join
    hold(1'b1, OS);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, OS);
    chk("par_bad_data_kept", o_data, 8'h07);
`endif

    hold(1'b1, OS);
    chk("events_drained", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
